front_combat_resolver: RTL and testbench

- Downstream of the battle-front finder.
- Once per game frame it consumes the latched fronts and target selects, checks whether the two front lines are engaged, and applies per-type damage to the frontmost friendly and enemy targets.
- It owns the HP registers for 16 unit slots, 16 enemy slots and both towers.
- It reports killed slots and game-over to the game controller.

---
 rtl/front_combat_resolver.sv | 178 +++++++++++++++++
 tb/tb_front_combat_resolver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/front_combat_resolver.sv
// rtl/front_combat_resolver.sv - per-frame front-line combat resolver owning slot and tower HP
// Latches fronts/selects, applies damage on a cooldown, and reports kills and game-over.
module front_combat_resolver #(
  parameter int unsigned HP_T1         = 20,
  parameter int unsigned HP_T2         = 40,
  parameter int unsigned HP_T3         = 80,
  parameter int unsigned DMG_T1        = 5,
  parameter int unsigned DMG_T2        = 10,
  parameter int unsigned DMG_T3        = 20,
  parameter int unsigned TOWER_HP      = 500,
  parameter int unsigned ATTACK_PERIOD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic        Ack,
  input  logic [8:0]  friendlyFront,
  input  logic [8:0]  enemyFront,
  input  logic [4:0]  unitDamageSelect,
  input  logic [4:0]  enemyDamageSelect,
  input  logic [1:0]  frontUnitType,
  input  logic [1:0]  frontEnemyType,
  input  logic        unitSpawn,
  input  logic [3:0]  unitSpawnSlot,
  input  logic [1:0]  unitSpawnType,
  input  logic        enemySpawn,
  input  logic [3:0]  enemySpawnSlot,
  input  logic [1:0]  enemySpawnType,
  output logic [15:0] unitKill,
  output logic [15:0] enemyKill,
  output logic [9:0]  friendlyTowerHP,
  output logic [9:0]  enemyTowerHP,
  output logic [1:0]  gameOver,
  output logic        Done
);

  localparam int CW = (ATTACK_PERIOD > 1) ? $clog2(ATTACK_PERIOD) : 1;
  localparam logic [CW-1:0] CD_RELOAD = CW'(ATTACK_PERIOD - 1);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    LATCH  = 5'b00010,
    HIT    = 5'b00100,
    REPORT = 5'b01000,
    DONE   = 5'b10000
  } state_t;

  state_t state, state_next;

  logic [7:0]    unit_hp  [16];
  logic [7:0]    enemy_hp [16];
  logic [CW-1:0] cooldown;
  logic [8:0]    friendly_front_q, enemy_front_q;
  logic [4:0]    unit_sel_q, enemy_sel_q;
  logic [1:0]    unit_type_q, enemy_type_q;

  logic          engaged, hit_en;
  logic [3:0]    unit_idx, enemy_idx;
  logic [7:0]    unit_old, unit_new, enemy_old, enemy_new;
  logic [9:0]    ftower_new, etower_new;

  function automatic logic [7:0] dmg_of(input logic [1:0] t);
    case (t)
      2'b01:   return DMG_T1[7:0];
      2'b10:   return DMG_T2[7:0];
      2'b11:   return DMG_T3[7:0];
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] spawn_hp(input logic [1:0] t);
    case (t)
      2'b01:   return HP_T1[7:0];
      2'b10:   return HP_T2[7:0];
      2'b11:   return HP_T3[7:0];
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a - b : 8'd0;
  endfunction

  function automatic logic [9:0] sat_sub10(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? a - b : 10'd0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = LATCH;
      LATCH:   state_next = HIT;
      HIT:     state_next = REPORT;
      REPORT:  state_next = DONE;
      DONE:    if (Ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Done = (state == DONE);

  // Friendly target is hit by the enemy attacker type and vice versa.
  always_comb begin
    engaged    = (enemy_front_q >= friendly_front_q);
    hit_en     = (state == HIT) && engaged && (cooldown == '0);
    unit_idx   = unit_sel_q[3:0];
    enemy_idx  = enemy_sel_q[3:0];
    unit_old   = unit_hp[unit_idx];
    enemy_old  = enemy_hp[enemy_idx];
    unit_new   = sat_sub8(unit_old, dmg_of(enemy_type_q));
    enemy_new  = sat_sub8(enemy_old, dmg_of(unit_type_q));
    ftower_new = sat_sub10(friendlyTowerHP, {2'b00, dmg_of(enemy_type_q)});
    etower_new = sat_sub10(enemyTowerHP, {2'b00, dmg_of(unit_type_q)});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        unit_hp[i]  <= '0;
        enemy_hp[i] <= '0;
      end
      friendlyTowerHP  <= TOWER_HP[9:0];
      enemyTowerHP     <= TOWER_HP[9:0];
      unitKill         <= '0;
      enemyKill        <= '0;
      gameOver         <= '0;
      cooldown         <= CD_RELOAD;
      friendly_front_q <= '0;
      enemy_front_q    <= '0;
      unit_sel_q       <= '0;
      enemy_sel_q      <= '0;
      unit_type_q      <= '0;
      enemy_type_q     <= '0;
    end else begin
      if (state == LATCH) begin
        friendly_front_q <= friendlyFront;
        enemy_front_q    <= enemyFront;
        unit_sel_q       <= unitDamageSelect;
        enemy_sel_q      <= enemyDamageSelect;
        unit_type_q      <= frontUnitType;
        enemy_type_q     <= frontEnemyType;
      end
      if (state == HIT && engaged)
        cooldown <= (cooldown == '0) ? CD_RELOAD : cooldown - 1'b1;
      if (hit_en) begin
        if (!unit_sel_q[4]) begin
          unit_hp[unit_idx] <= unit_new;
          if (unit_old != 8'd0 && unit_new == 8'd0 && !(unitSpawn && unitSpawnSlot == unit_idx))
            unitKill[unit_idx] <= 1'b1;
        end else if (unit_sel_q[3:0] == 4'd0) begin
          friendlyTowerHP <= ftower_new;
          if (ftower_new == 10'd0) gameOver[0] <= 1'b1;
        end
        if (!enemy_sel_q[4]) begin
          enemy_hp[enemy_idx] <= enemy_new;
          if (enemy_old != 8'd0 && enemy_new == 8'd0 && !(enemySpawn && enemySpawnSlot == enemy_idx))
            enemyKill[enemy_idx] <= 1'b1;
        end else if (enemy_sel_q[3:0] == 4'd0) begin
          enemyTowerHP <= etower_new;
          if (etower_new == 10'd0) gameOver[1] <= 1'b1;
        end
      end
      if (state == DONE && Ack) begin
        unitKill  <= '0;
        enemyKill <= '0;
      end
      // Spawns are written last so they override a same-cycle hit.
      if (unitSpawn)  unit_hp[unitSpawnSlot]   <= spawn_hp(unitSpawnType);
      if (enemySpawn) enemy_hp[enemySpawnSlot] <= spawn_hp(enemySpawnType);
    end
  end

endmodule

// File: tb/tb_front_combat_resolver.sv
// tb/tb_front_combat_resolver.sv - directed bench for front_combat_resolver
// Hand-computed expectations; a tiny cooldown model decides which frames hit.
module tb_front_combat_resolver;

  logic        clk = 1'b0;
  logic        rst, Start, Ack;
  logic [8:0]  friendlyFront, enemyFront;
  logic [4:0]  unitDamageSelect, enemyDamageSelect;
  logic [1:0]  frontUnitType, frontEnemyType;
  logic        unitSpawn, enemySpawn;
  logic [3:0]  unitSpawnSlot, enemySpawnSlot;
  logic [1:0]  unitSpawnType, enemySpawnType;
  logic [15:0] unitKill, enemyKill;
  logic [9:0]  friendlyTowerHP, enemyTowerHP;
  logic [1:0]  gameOver;
  logic        Done;

  int n_cmp = 0;
  int n_err = 0;
  int mcd   = 3;
  int exp_ft;
  bit hit;

  always #5 clk = ~clk;

  front_combat_resolver dut (
    .clk(clk), .rst(rst), .Start(Start), .Ack(Ack),
    .friendlyFront(friendlyFront), .enemyFront(enemyFront),
    .unitDamageSelect(unitDamageSelect), .enemyDamageSelect(enemyDamageSelect),
    .frontUnitType(frontUnitType), .frontEnemyType(frontEnemyType),
    .unitSpawn(unitSpawn), .unitSpawnSlot(unitSpawnSlot), .unitSpawnType(unitSpawnType),
    .enemySpawn(enemySpawn), .enemySpawnSlot(enemySpawnSlot), .enemySpawnType(enemySpawnType),
    .unitKill(unitKill), .enemyKill(enemyKill),
    .friendlyTowerHP(friendlyTowerHP), .enemyTowerHP(enemyTowerHP),
    .gameOver(gameOver), .Done(Done)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Runs one frame up to DONE; optional spawn of unit slot 3 (type 01) during HIT.
  task automatic frame(input logic [8:0] ff, input logic [8:0] ef,
                       input logic [4:0] us, input logic [4:0] es,
                       input logic [1:0] ut, input logic [1:0] et,
                       input bit spawn_hit, output bit hit_o);
    hit_o = 1'b0;
    if (ef >= ff) begin
      if (mcd == 0) begin hit_o = 1'b1; mcd = 3; end
      else mcd--;
    end
    friendlyFront = ff; enemyFront = ef;
    unitDamageSelect = us; enemyDamageSelect = es;
    frontUnitType = ut; frontEnemyType = et;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    if (spawn_hit) begin
      unitSpawn = 1'b1; unitSpawnSlot = 4'd3; unitSpawnType = 2'b01;
    end
    tick();
    unitSpawn = 1'b0;
    chk("done_low_n3", Done, 0);
    tick();
    chk("done_high_n4", Done, 1);
  endtask

  task automatic ack();
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; Start = 0; Ack = 0;
    friendlyFront = 0; enemyFront = 0;
    unitDamageSelect = 0; enemyDamageSelect = 0;
    frontUnitType = 0; frontEnemyType = 0;
    unitSpawn = 0; unitSpawnSlot = 0; unitSpawnType = 0;
    enemySpawn = 0; enemySpawnSlot = 0; enemySpawnType = 0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;

    chk("rst_done", Done, 0);
    chk("rst_ftower", friendlyTowerHP, 500);
    chk("rst_etower", enemyTowerHP, 500);
    chk("rst_gameover", gameOver, 0);
    chk("rst_ukill", unitKill, 0);
    chk("rst_ekill", enemyKill, 0);
    chk("rst_cooldown", dut.cooldown, 3);
    chk("rst_unit3", dut.unit_hp[3], 0);

    unitSpawn = 1; unitSpawnSlot = 3; unitSpawnType = 2'b01;
    enemySpawn = 1; enemySpawnSlot = 5; enemySpawnType = 2'b10;
    tick();
    unitSpawn = 0; enemySpawn = 0;
    chk("spawn_unit3", dut.unit_hp[3], 20);
    chk("spawn_enemy5", dut.enemy_hp[5], 40);

    // Engaged frames with type-00 attackers drain the cooldown without damage.
    for (int i = 0; i < 3; i++) begin
      frame(200, 210, 3, 5, 2'b00, 2'b00, 0, hit);
      ack();
    end
    chk("warm_cooldown", dut.cooldown, 0);
    chk("warm_unit3", dut.unit_hp[3], 20);

    frame(200, 210, 3, 5, 2'b01, 2'b10, 0, hit);
    chk("f1_unit3", dut.unit_hp[3], 10);
    chk("f1_enemy5", dut.enemy_hp[5], 35);
    chk("f1_ukill", unitKill, 0);
    chk("f1_ekill", enemyKill, 0);
    ack();

    for (int i = 0; i < 3; i++) begin
      frame(200, 210, 3, 5, 2'b01, 2'b10, 0, hit);
      chk("f234_unit3", dut.unit_hp[3], 10);
      chk("f234_enemy5", dut.enemy_hp[5], 35);
      ack();
    end

    frame(200, 210, 3, 5, 2'b01, 2'b10, 0, hit);
    chk("f5_unit3", dut.unit_hp[3], 0);
    chk("f5_enemy5", dut.enemy_hp[5], 30);
    chk("f5_ukill", unitKill, 16'h0008);
    tick(); tick();
    chk("f5_ukill_held", unitKill, 16'h0008);
    chk("f5_done_held", Done, 1);
    ack();
    chk("f5_ukill_clr", unitKill, 0);
    chk("f5_done_clr", Done, 0);

    for (int i = 0; i < 10; i++) begin
      frame(300, 100, 3, 5, 2'b11, 2'b11, 0, hit);
      ack();
    end
    chk("ne_cooldown", dut.cooldown, 3);
    chk("ne_enemy5", dut.enemy_hp[5], 30);
    chk("ne_ftower", friendlyTowerHP, 500);

    // Walk the friendly tower down to 20, then 15 with a type-01 hit, then saturate.
    exp_ft = 500;
    for (int k = 0; k < 200 && exp_ft != 0; k++) begin
      logic [1:0] et;
      int d;
      et = (exp_ft == 20) ? 2'b01 : 2'b11;
      d  = (et == 2'b01) ? 5 : 20;
      frame(200, 210, 5'd16, 5'd17, 2'b00, et, 0, hit);
      if (hit) exp_ft = (exp_ft > d) ? exp_ft - d : 0;
      chk("tower_ftower", friendlyTowerHP, exp_ft);
      chk("tower_gameover", gameOver, (exp_ft == 0) ? 1 : 0);
      ack();
    end
    chk("tower_reached0", friendlyTowerHP, 0);
    chk("tower_etower", enemyTowerHP, 500);
    for (int i = 0; i < 5; i++) begin
      frame(300, 100, 5'd16, 5'd17, 2'b00, 2'b11, 0, hit);
      ack();
    end
    chk("tower_gameover_sticky", gameOver, 2'b01);

    unitSpawn = 1; unitSpawnSlot = 3; unitSpawnType = 2'b01;
    tick();
    unitSpawn = 0;
    for (int k = 0; k < 8 && mcd != 0; k++) begin
      frame(200, 210, 3, 5'd17, 2'b00, 2'b00, 0, hit);
      ack();
    end
    chk("pre_lethal_cd", dut.cooldown, 0);
    frame(200, 210, 3, 5'd17, 2'b00, 2'b11, 1, hit);
    chk("spawnwin_unit3", dut.unit_hp[3], 20);
    chk("spawnwin_ukill", unitKill, 0);
    ack();

    friendlyFront = 200; enemyFront = 210;
    unitDamageSelect = 3; enemyDamageSelect = 5;
    frontUnitType = 2'b11; frontEnemyType = 2'b11;
    Start = 1;
    tick();
    Start = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_state", dut.state, 5'b00001);
    chk("midrst_unit3", dut.unit_hp[3], 0);
    chk("midrst_enemy5", dut.enemy_hp[5], 0);
    chk("midrst_ftower", friendlyTowerHP, 500);
    chk("midrst_etower", enemyTowerHP, 500);
    chk("midrst_done", Done, 0);
    chk("midrst_gameover", gameOver, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
